// File: rtl/pipe_mem_elastic.sv
// rtl/pipe_mem_elastic.sv - H-stage elastic delay line with valid/ready, bubble collapse and flush
// in_ready is a combinational function of out_ready through all H stages; keep H<=8 at instantiation.
module pipe_mem_elastic #(
   parameter int W          = 32,
   parameter int H          = 3,
   parameter bit RESET_DATA = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [W-1:0]           in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [W-1:0]           out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   input  logic                   flush,
   output logic [$clog2(H+1)-1:0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int CW = $clog2(H+1);

   logic [H-1:0]  v_q, v_d, en;
   logic [W-1:0]  d_q [H];
   logic [W-1:0]  d_d [H];
   logic [CW-1:0] count_q, count_d;
   logic          in_fire, out_fire;

   // A stage loads when anything downstream of it can move or it is itself empty.
   always_comb begin
      logic acc;
      acc     = out_ready | ~v_q[H-1];
      en[H-1] = acc;
      for (int i = H - 2; i >= 0; i--) begin
         acc   = acc | ~v_q[i];
         en[i] = acc;
      end
   end

   assign in_ready = en[0] & ~flush;
   assign in_fire  = in_valid & in_ready;
   assign out_fire = v_q[H-1] & out_ready;

   always_comb begin
      v_d     = v_q;
      count_d = count_q;
      for (int i = 0; i < H; i++) d_d[i] = d_q[i];
      if (flush) begin
         v_d     = '0;
         count_d = '0;
      end else begin
         if (en[0]) begin
            v_d[0] = in_valid;
            d_d[0] = in_data;
         end
         for (int i = 1; i < H; i++) begin
            if (en[i]) begin
               v_d[i] = v_q[i-1];
               d_d[i] = d_q[i-1];
            end
         end
         count_d = count_q + CW'(in_fire) - CW'(out_fire);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q     <= '0;
         count_q <= '0;
      end else begin
         v_q     <= v_d;
         count_q <= count_d;
      end
   end

   generate
      if (RESET_DATA) begin : g_rst_data
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int i = 0; i < H; i++) d_q[i] <= '0;
            end else begin
               for (int i = 0; i < H; i++) d_q[i] <= d_d[i];
            end
         end
      end else begin : g_nrst_data
         always_ff @(posedge clk) begin
            for (int i = 0; i < H; i++) d_q[i] <= d_d[i];
         end
      end
   endgenerate

   assign out_valid = v_q[H-1];
   assign out_data  = d_q[H-1];
   assign count     = count_q;
   assign full      = (count_q == CW'(H));
   assign empty     = (count_q == '0);
endmodule

// File: tb/tb_pipe_mem_elastic.sv
// tb/tb_pipe_mem_elastic.sv - self-checking bench for pipe_mem_elastic (W=32, H=3)
module tb_pipe_mem_elastic;
   localparam int W  = 32;
   localparam int H  = 3;
   localparam int CW = $clog2(H+1);

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  in_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready;
   logic          flush;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;

   pipe_mem_elastic #(.W(W), .H(H), .RESET_DATA(1'b1)) dut (
      .clk(clk), .reset(reset),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   // Reference: FIFO of accepted samples, each with its depth into the pipe.
   // A sample advances each cycle unless the samples ahead of it fill every
   // slot between it and the output; it is visible once it reaches depth H-1.
   typedef struct {
      logic [31:0] data;
      int          pos;
   } item_t;

   item_t       mq[$];
   logic [31:0] fired[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic        obs_in_ready;
   logic        obs_out_fire;
   logic [31:0] obs_out_data;

   task automatic drive_cycle(input logic iv, input logic [31:0] id, input logic orr, input logic fl);
      logic  ifire;
      item_t it;
      in_valid  = iv;
      in_data   = id;
      out_ready = orr;
      flush     = fl;
      #1;
      obs_in_ready = in_ready;
      obs_out_fire = out_valid & orr;
      obs_out_data = out_data;
      ifire        = iv & in_ready;
      if (obs_out_fire) fired.push_back(obs_out_data);
      @(posedge clk);
      if (fl) begin
         mq.delete();
      end else begin
         if (obs_out_fire && mq.size() > 0) void'(mq.pop_front());
         for (int j = 0; j < mq.size(); j++)
            if (mq[j].pos < H - 1 - j) mq[j].pos = mq[j].pos + 1;
         if (ifire) begin
            it.data = id;
            it.pos  = 0;
            mq.push_back(it);
         end
      end
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < H + 2; k++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
      n_tests++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags got empty=%0b full=%0b exp empty=1 full=0", empty, full); end
      n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
      reset = 1'b0;
      #1;
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_stream();
      for (int s = 1; s <= 13; s++) begin
         drive_cycle(s <= 10, 32'(s), 1'b1, 1'b0);
         if (s <= 10) begin
            n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready s=%0d got=%0b exp=1", s, obs_in_ready); end
         end
         if (s >= 3 && s <= 12) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(s - 2)) begin
               n_fail++; $display("FAIL stream_out s=%0d got v=%0b d=%0h exp v=1 d=%0h", s, out_valid, out_data, s - 2);
            end
         end
         if (s >= 3 && s <= 10) begin
            n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL stream_count s=%0d got=%0d exp=3", s, count); end
         end
      end
      n_tests++; if (count !== '0 || empty !== 1'b1) begin n_fail++; $display("FAIL stream_end got count=%0d empty=%0b exp 0 1", count, empty); end
   endtask

   task automatic test_backpressure();
      for (int k = 5; k <= 7; k++) begin
         drive_cycle(1'b1, 32'(k), 1'b0, 1'b0);
         n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept k=%0d got=%0b exp=1", k, obs_in_ready); end
      end
      drive_cycle(1'b1, 32'd8, 1'b0, 1'b0);
      n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall got=%0b exp=0", obs_in_ready); end
      n_tests++;
      if (count !== CW'(3) || full !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'd5) begin
         n_fail++; $display("FAIL bp_full got count=%0d full=%0b v=%0b d=%0h exp 3 1 1 5", count, full, out_valid, out_data);
      end
      fired.delete();
      drive_cycle(1'b1, 32'd8, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (fired.size() != 4 || fired[0] !== 32'd5 || fired[1] !== 32'd6 || fired[2] !== 32'd7 || fired[3] !== 32'd8) begin
         n_fail++; $display("FAIL bp_order got n=%0d exp n=4 seq 5,6,7,8", fired.size());
      end
   endtask

   task automatic test_bubble_collapse();
      logic [31:0] vals[3];
      for (int k = 0; k < 3; k++) vals[k] = $urandom;
      for (int k = 0; k < 3; k++) begin
         drive_cycle(1'b1, vals[k], 1'b0, 1'b0);
         n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL bubble_accept k=%0d got=%0b exp=1", k, obs_in_ready); end
         drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
      end
      n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL bubble_count got=%0d exp=3", count); end
      drive_cycle(1'b1, 32'hdead, 1'b0, 1'b0);
      n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL bubble_stall got=%0b exp=0", obs_in_ready); end
      fired.delete();
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (fired.size() != 3 || fired[0] !== vals[0] || fired[1] !== vals[1] || fired[2] !== vals[2]) begin
         n_fail++; $display("FAIL bubble_order got n=%0d exp n=3 in order", fired.size());
      end
      drain();
   endtask

   task automatic test_full_simultaneous();
      for (int k = 21; k <= 23; k++) drive_cycle(1'b1, 32'(k), 1'b0, 1'b0);
      fired.delete();
      drive_cycle(1'b1, 32'd9, 1'b1, 1'b0);
      n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL fullsim_in_ready got=%0b exp=1", obs_in_ready); end
      n_tests++; if (count !== CW'(3)) begin n_fail++; $display("FAIL fullsim_count got=%0d exp=3", count); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++; if (out_valid !== 1'b1 || out_data !== 32'd9) begin n_fail++; $display("FAIL fullsim_latency got v=%0b d=%0h exp v=1 d=9", out_valid, out_data); end
      drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++;
      if (fired.size() != 4 || fired[0] !== 32'd21 || fired[1] !== 32'd22 || fired[2] !== 32'd23 || fired[3] !== 32'd9) begin
         n_fail++; $display("FAIL fullsim_order got n=%0d exp n=4 seq 21,22,23,9", fired.size());
      end
   endtask

   task automatic test_flush();
      drive_cycle(1'b1, 32'h31, 1'b0, 1'b0);
      drive_cycle(1'b1, 32'h32, 1'b0, 1'b0);
      n_tests++; if (count !== CW'(2)) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=2", count); end
      drive_cycle(1'b1, 32'haa, 1'b0, 1'b1);
      n_tests++; if (obs_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready got=%0b exp=0", obs_in_ready); end
      n_tests++;
      if (out_valid !== 1'b0 || count !== '0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL flush_state got v=%0b count=%0d empty=%0b exp 0 0 1", out_valid, count, empty);
      end
      fired.delete();
      for (int k = 0; k < 5; k++) drive_cycle(1'b0, 32'h0, 1'b1, 1'b0);
      n_tests++; if (fired.size() != 0) begin n_fail++; $display("FAIL flush_leak got n=%0d exp n=0", fired.size()); end
   endtask

   task automatic test_async_reset();
      drive_cycle(1'b1, 32'h41, 1'b1, 1'b0);
      drive_cycle(1'b1, 32'h42, 1'b1, 1'b0);
      in_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || count !== '0 || out_data !== 32'h0) begin
         n_fail++; $display("FAIL areset_immediate got v=%0b count=%0d d=%0h exp 0 0 0", out_valid, count, out_data);
      end
      mq.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int s = 1; s <= 3; s++) begin
         drive_cycle(1'b1, 32'h50 + 32'(s), 1'b1, 1'b0);
         n_tests++; if (obs_in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready s=%0d got=%0b exp=1", s, obs_in_ready); end
         if (s == 2) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_early got=%0b exp=0", out_valid); end
         end
      end
      n_tests++; if (out_valid !== 1'b1 || out_data !== 32'h51) begin n_fail++; $display("FAIL areset_latency got v=%0b d=%0h exp v=1 d=51", out_valid, out_data); end
      drain();
   endtask

   task automatic test_random();
      logic        iv, orr, fl, exp_ir, exp_ov;
      logic [31:0] id;
      for (int k = 0; k < 600; k++) begin
         iv     = 1'($urandom_range(0, 1));
         orr    = ((k / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         fl     = ($urandom_range(0, 39) == 0);
         id     = $urandom;
         exp_ir = !fl && (orr || mq.size() < H);
         drive_cycle(iv, id, orr, fl);
         exp_ov = (mq.size() > 0) && (mq[0].pos == H - 1);
         n_tests++; if (obs_in_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_in_ready k=%0d got=%0b exp=%0b", k, obs_in_ready, exp_ir); end
         n_tests++; if (out_valid !== exp_ov) begin n_fail++; $display("FAIL rnd_out_valid k=%0d got=%0b exp=%0b", k, out_valid, exp_ov); end
         if (exp_ov) begin
            n_tests++; if (out_data !== mq[0].data) begin n_fail++; $display("FAIL rnd_out_data k=%0d got=%0h exp=%0h", k, out_data, mq[0].data); end
         end
         n_tests++; if (count !== CW'(mq.size()) || count > CW'(H)) begin n_fail++; $display("FAIL rnd_count k=%0d got=%0d exp=%0d", k, count, mq.size()); end
         n_tests++;
         if (full !== (mq.size() == H) || empty !== (mq.size() == 0)) begin
            n_fail++; $display("FAIL rnd_flags k=%0d got full=%0b empty=%0b exp occupancy=%0d", k, full, empty, mq.size());
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_stream();
      test_backpressure();
      test_bubble_collapse();
      test_full_simultaneous();
      test_flush();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
